// File: rtl/dial_pkg.sv
// Shared types and helpers for the dial positioner: FSM states, stepper phase encodings,
// per-segment step cost and shortest-direction selection.
package dial_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSeg,
    StStep,
    StDone
  } dial_state_e;

  localparam logic [3:0] Phase0Oh = 4'b0001;
  localparam logic [3:0] Phase1Oh = 4'b0010;
  localparam logic [3:0] Phase2Oh = 4'b0100;
  localparam logic [3:0] Phase3Oh = 4'b1000;

  function automatic logic [3:0] phase_onehot(input logic [1:0] phase);
    logic [3:0] oh;
    unique case (phase)
      2'd0: oh = Phase0Oh;
      2'd1: oh = Phase1Oh;
      2'd2: oh = Phase2Oh;
      2'd3: oh = Phase3Oh;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // Every GROUP-th segment carries one extra motor step.
  function automatic int unsigned seg_cost(input int unsigned seg,
                                           input int unsigned steps_per_pos,
                                           input int unsigned group);
    return steps_per_pos + (((seg % group) == (group - 1)) ? 32'd1 : 32'd0);
  endfunction

  // Returns {move, dir}; dir=1 is forward, and the half-dial tie resolves forward.
  function automatic logic [1:0] shortest_dir(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned n_pos);
    int unsigned d_f;
    d_f = (tgt + n_pos - cur) % n_pos;
    return {d_f != 32'd0, d_f <= (n_pos / 2)};
  endfunction

endpackage

// File: rtl/dial_positioner_if.sv
// Request/motor bundle between the position decode (master) and the dial positioner (slave).
interface dial_positioner_if #(
  parameter int unsigned PW = 5
) ();

  logic          req;
  logic [PW-1:0] target_pos;
  logic          ready;
  logic          busy;
  logic [3:0]    motor_drv;
  logic [PW-1:0] cur_pos;
  logic          dir;
  logic          move_done;

  modport master (
    output req,
    output target_pos,
    input  ready,
    input  busy,
    input  motor_drv,
    input  cur_pos,
    input  dir,
    input  move_done
  );

  modport slave (
    input  req,
    input  target_pos,
    output ready,
    output busy,
    output motor_drv,
    output cur_pos,
    output dir,
    output move_done
  );

endinterface

// File: rtl/dial_tick_gen.sv
// Motor-rate prescaler: pulses tick_o every ClkDiv enabled cycles, held at zero when disabled.
module dial_tick_gen #(
  parameter int unsigned ClkDiv = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign tick_o = enable_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !enable_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dial_positioner.sv
// Drives a 4-phase stepper to a requested dial position by the shortest route.
// Define DIAL_PENDING_EN to add a one-entry buffer for a request made while busy.
module dial_positioner
  import dial_pkg::*;
#(
  parameter int unsigned N_POS         = 32,
  parameter int unsigned STEPS_PER_POS = 6,
  parameter int unsigned GROUP         = 4,
  parameter int unsigned CLK_DIV       = 1
) (
  input logic          sys_clk,
  input logic          reset,
  dial_positioner_if.slave bus
);

  localparam int unsigned PW      = $clog2(N_POS);
  localparam int unsigned SegCntW = $clog2(STEPS_PER_POS + 2);

  dial_state_e        state_d, state_q;
  logic [PW-1:0]      cur_pos_d, cur_pos_q;
  logic [PW-1:0]      tgt_d, tgt_q;
  logic               dir_d, dir_q;
  logic [1:0]         phase_d, phase_q;
  logic [SegCntW-1:0] seg_cnt_d, seg_cnt_q;
  logic [3:0]         motor_drv_d, motor_drv_q;
  logic               move_done_d, move_done_q;

  logic               ready;
  logic               accept;
  logic               start;
  logic [PW-1:0]      start_tgt;
  logic [1:0]         move_dir;
  logic [PW-1:0]      seg_idx;
  logic [PW-1:0]      next_pos;
  logic               tick;

`ifdef DIAL_PENDING_EN
  logic               pend_valid_d, pend_valid_q;
  logic [PW-1:0]      pend_tgt_d, pend_tgt_q;

  assign ready = (state_q == StIdle) || !pend_valid_q;
`else
  assign ready = (state_q == StIdle);
`endif

  assign accept   = bus.req && ready;
  // Reverse travel from p crosses the segment that ends at p.
  assign seg_idx  = dir_q ? cur_pos_q : cur_pos_q - PW'(1);
  assign next_pos = dir_q ? cur_pos_q + PW'(1) : cur_pos_q - PW'(1);

  dial_tick_gen #(
    .ClkDiv(CLK_DIV)
  ) u_tick_gen (
    .clk_i    (sys_clk),
    .rst_i    (reset),
    .restart_i(start),
    .enable_i (state_q == StStep),
    .tick_o   (tick)
  );

  always_comb begin
    state_d   = state_q;
    cur_pos_d = cur_pos_q;
    tgt_d     = tgt_q;
    dir_d     = dir_q;
    phase_d   = phase_q;
    seg_cnt_d = seg_cnt_q;
    start     = 1'b0;
    start_tgt = bus.target_pos;
`ifdef DIAL_PENDING_EN
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
`endif

    unique case (state_q)
      StIdle: begin
        start = accept;
      end
      StSeg: begin
        seg_cnt_d = SegCntW'(seg_cost(32'(seg_idx), STEPS_PER_POS, GROUP));
        state_d   = StStep;
      end
      StStep: begin
        if (tick) begin
          phase_d   = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
          seg_cnt_d = seg_cnt_q - SegCntW'(1);
          if (seg_cnt_q == SegCntW'(1)) begin
            cur_pos_d = next_pos;
            state_d   = (next_pos == tgt_q) ? StDone : StSeg;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef DIAL_PENDING_EN
        // A buffered request chains straight into the next move without visiting idle.
        if (pend_valid_q) begin
          start        = 1'b1;
          start_tgt    = pend_tgt_q;
          pend_valid_d = 1'b0;
        end else begin
          start = accept;
        end
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef DIAL_PENDING_EN
    if (accept && ((state_q == StSeg) || (state_q == StStep))) begin
      pend_valid_d = 1'b1;
      pend_tgt_d   = bus.target_pos;
    end
`endif

    move_dir = shortest_dir(32'(cur_pos_q), 32'(start_tgt), N_POS);
    if (start) begin
      tgt_d   = start_tgt;
      dir_d   = move_dir[0];
      state_d = move_dir[1] ? StSeg : StDone;
    end

    motor_drv_d = (state_q == StStep) ? phase_onehot(phase_d) : 4'b0000;
    move_done_d = (state_q == StDone);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_pos_q   <= '0;
      tgt_q       <= '0;
      dir_q       <= 1'b1;
      phase_q     <= 2'd0;
      seg_cnt_q   <= '0;
      motor_drv_q <= 4'b0000;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_pos_q   <= cur_pos_d;
      tgt_q       <= tgt_d;
      dir_q       <= dir_d;
      phase_q     <= phase_d;
      seg_cnt_q   <= seg_cnt_d;
      motor_drv_q <= motor_drv_d;
      move_done_q <= move_done_d;
    end
  end

`ifdef DIAL_PENDING_EN
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end
`endif

  assign bus.ready     = ready;
  assign bus.busy      = (state_q != StIdle);
  assign bus.motor_drv = motor_drv_q;
  assign bus.cur_pos   = cur_pos_q;
  assign bus.dir       = dir_q;
  assign bus.move_done = move_done_q;

endmodule

// File: tb/tb_dial_positioner.sv
// Randomized bench for dial_positioner against a step-list reference model of dial travel.
module tb_dial_positioner;

  localparam int NPos = 32;
  localparam int Spp  = 6;
  localparam int Grp  = 4;
  localparam int PW   = 5;

  logic sys_clk = 1'b0;
  logic reset;

  always #5 sys_clk = ~sys_clk;

  dial_positioner_if #(.PW(PW)) bus ();
  dial_positioner_if #(.PW(PW)) bus3 ();

  dial_positioner #(
    .N_POS(NPos), .STEPS_PER_POS(Spp), .GROUP(Grp), .CLK_DIV(1)
  ) u_dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  dial_positioner #(
    .N_POS(NPos), .STEPS_PER_POS(Spp), .GROUP(Grp), .CLK_DIV(3)
  ) u_dut3 (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus3)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_pos = 0;
  int m_phase = 0;
  int exp_q[$];
  int got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cost(input int s);
    return Spp + (((s % Grp) == (Grp - 1)) ? 1 : 0);
  endfunction

  // Appends the expected phase pattern of one move to exp_q and advances the model.
  task automatic model_move(input int tgt, output int lat, output int nseg);
    int df, fwd, p, s;
    df   = (tgt - m_pos + NPos) % NPos;
    fwd  = (df != 0 && df <= NPos / 2) ? 1 : 0;
    lat  = 2;
    nseg = 0;
    p    = m_pos;
    while (p != tgt) begin
      s = fwd ? p : (p + NPos - 1) % NPos;
      for (int k = 0; k < cost(s); k++) begin
        m_phase = fwd ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
        exp_q.push_back(1 << m_phase);
      end
      lat += 1 + cost(s);
      p = fwd ? (p + 1) % NPos : (p + NPos - 1) % NPos;
      nseg++;
    end
    m_pos = tgt;
  endtask

  task automatic compare_seq(input string tag);
    check_eq({tag, "_nsteps"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_drv%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // One move on the CLK_DIV=1 instance; mid_at >= 0 pulses a stray req on that cycle.
  task automatic do_move(input int tgt, input int mid_at, input int mid_tgt);
    int df, fwd, exp_lat, nseg, lat, gaps;
    bit done, seen_nz, in_gap;
    df  = (tgt - m_pos + NPos) % NPos;
    fwd = (df != 0 && df <= NPos / 2) ? 1 : 0;
    exp_q.delete();
    got_q.delete();
    model_move(tgt, exp_lat, nseg);
    @(negedge sys_clk);
    check_eq("ready_pre", 32'(bus.ready), 32'd1);
    bus.req        = 1'b1;
    bus.target_pos = PW'(tgt);
    @(negedge sys_clk);
    bus.req        = 1'b0;
    bus.target_pos = PW'($urandom);
    check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
    if (df != 0) check_eq("dir", 32'(bus.dir), 32'(fwd));
    lat = 1; gaps = 0; done = 0; seen_nz = 0; in_gap = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (bus.move_done) begin
        done = 1;
      end else begin
        if (bus.motor_drv != 4'b0000) begin
          got_q.push_back(int'(bus.motor_drv));
          if (in_gap) gaps++;
          seen_nz = 1;
          in_gap  = 0;
        end else if (seen_nz) begin
          in_gap = 1;
        end
        bus.req = (c == mid_at);
        if (c == mid_at) bus.target_pos = PW'(mid_tgt);
        @(negedge sys_clk);
        lat++;
      end
    end
    bus.req = 1'b0;
    check_eq("move_done_seen", 32'(done), 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    compare_seq("move");
    check_eq("seg_gaps", 32'(gaps), 32'((nseg > 0) ? nseg - 1 : 0));
    check_eq("cur_pos", 32'(bus.cur_pos), 32'(tgt));
    @(negedge sys_clk);
    check_eq("done_width", 32'(bus.move_done), 32'd0);
    check_eq("ready_post", 32'(bus.ready), 32'd1);
    check_eq("busy_post", 32'(bus.busy), 32'd0);
  endtask

`ifdef DIAL_PENDING_EN
  task automatic pending_case(input int tgt_a);
    int lat_a, ns_a, lat_b, ns_b, dones;
    bit dropped;
    exp_q.delete();
    got_q.delete();
    model_move(tgt_a, lat_a, ns_a);
    model_move(8, lat_b, ns_b);
    @(negedge sys_clk);
    bus.req = 1'b1; bus.target_pos = PW'(tgt_a);
    @(negedge sys_clk);
    bus.req = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("pend_ready_busy", 32'(bus.ready), 32'd1);
    bus.req = 1'b1; bus.target_pos = PW'(8);
    @(negedge sys_clk);
    bus.req = 1'b0;
    check_eq("pend_full_ready", 32'(bus.ready), 32'd0);
    dones = 0; dropped = 0;
    for (int c = 0; c < 3000 && dones < 2; c++) begin
      if (bus.move_done) dones++;
      if (dones < 2 && !bus.busy) dropped = 1;
      if (bus.motor_drv != 4'b0000) got_q.push_back(int'(bus.motor_drv));
      if (dones < 2) @(negedge sys_clk);
    end
    check_eq("pend_dones", 32'(dones), 32'd2);
    check_eq("pend_no_idle", 32'(dropped), 32'd0);
    compare_seq("pend");
    check_eq("pend_cur_pos", 32'(bus.cur_pos), 32'd8);
    @(negedge sys_clk);
  endtask
`endif

  initial begin
    int t, last_t, nchg, prev, tgt, wait_c;
    reset = 1'b1;
    bus.req = 1'b0;  bus.target_pos = '0;
    bus3.req = 1'b0; bus3.target_pos = '0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_cur_pos", 32'(bus.cur_pos), 32'd0);
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_motor", 32'(bus.motor_drv), 32'd0);
    check_eq("rst_done", 32'(bus.move_done), 32'd0);
    reset = 1'b0;

    // CLK_DIV=3 instance: 0 -> 1, six steps with changes three cycles apart.
    @(negedge sys_clk);
    bus3.req = 1'b1; bus3.target_pos = PW'(1);
    @(negedge sys_clk);
    bus3.req = 1'b0;
    prev = 1; t = 1; last_t = 0; nchg = 0;
    for (int c = 0; c < 200 && !bus3.move_done; c++) begin
      if (bus3.motor_drv != 4'b0000 && int'(bus3.motor_drv) != prev) begin
        nchg++;
        check_eq("div3_drv", 32'(bus3.motor_drv), 32'(1 << (nchg % 4)));
        if (nchg > 1) check_eq("div3_spacing", 32'(t - last_t), 32'd3);
        last_t = t;
        prev   = int'(bus3.motor_drv);
      end
      @(negedge sys_clk);
      t++;
    end
    check_eq("div3_steps", 32'(nchg), 32'd6);
    check_eq("div3_latency", 32'(t), 32'd21);
    check_eq("div3_cur_pos", 32'(bus3.cur_pos), 32'd1);

    // Directed moves on the CLK_DIV=1 instance.
    do_move(1, -1, 0);
    do_move(0, -1, 0);
    do_move(31, -1, 0);
    do_move(0, -1, 0);
    do_move(16, -1, 0);
    do_move(16, -1, 0);
`ifdef DIAL_PENDING_EN
    pending_case((m_pos + 5) % NPos);
`else
    do_move(20, 5, 3);
`endif

    // Reset in the middle of stepping aborts the move.
    @(negedge sys_clk);
    bus.req = 1'b1; bus.target_pos = PW'((m_pos + 12) % NPos);
    @(negedge sys_clk);
    bus.req = 1'b0;
    wait_c = 0;
    while (bus.motor_drv == 4'b0000 && wait_c < 100) begin
      @(negedge sys_clk);
      wait_c++;
    end
    check_eq("midstep_reached", 32'(wait_c < 100), 32'd1);
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    check_eq("abort_motor", 32'(bus.motor_drv), 32'd0);
    check_eq("abort_cur_pos", 32'(bus.cur_pos), 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_ready", 32'(bus.ready), 32'd1);
    m_pos = 0;
    m_phase = 0;
    do_move(3, -1, 0);

    for (int i = 0; i < 14; i++) begin
      tgt = (i % 5 == 4) ? m_pos : int'($urandom_range(0, NPos - 1));
      do_move(tgt, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
